control: RTL and testbench

//  ID-stage main decoder of the 5-stage RV32I pipeline. Maps the pre-decoded opcode enum
//  (opcode_out_t, from the instruction decoder) to every datapath control signal.
//  The signals are registered into ID/EX by the pipeline, not here. Pure combinational

---
 rtl/control_pkg.sv | 143 ++++++++++++++
 rtl/control_if.sv | 50 +++++
 rtl/control.sv | 95 +++++++++
 tb/tb_control.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// -----------------------------------------------------------------------------
// control_pkg
//   Types shared by the ID-stage main decoder and its neighbours:
//     opcode_out_t  - pre-decoded instruction enum from the instruction decoder
//     comp_op_t     - branch comparator operation
//     reg_wr_src_t  - register-file write-back source
//     alu_src1_t    - ALU operand A select
//     alu_src2_t    - ALU operand B select
//     alu_op_t      - ALU operation
//     mem_op_t      - data-memory access width/sign
//     ctrl_t        - bundle of every control signal the decoder produces
//   The helper functions build a complete control word for each instruction
//   class on top of CTRL_DEFAULT, so each class is described exactly once.
// -----------------------------------------------------------------------------
package control_pkg;

  typedef enum logic [5:0] {
    OP_NOP,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
    OP_SRL, OP_SRA, OP_OR, OP_AND
  } opcode_out_t;

  typedef enum logic [2:0] {
    BR_NOP, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU
  } comp_op_t;

  typedef enum logic [1:0] {
    WRSRC_ALURES, WRSRC_MEMREAD, WRSRC_PC4
  } reg_wr_src_t;

  typedef enum logic {
    SRC1_REG1, SRC1_PC
  } alu_src1_t;

  typedef enum logic {
    SRC2_REG2, SRC2_IMM
  } alu_src2_t;

  typedef enum logic [3:0] {
    ALU_NOP, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI
  } alu_op_t;

  typedef enum logic [3:0] {
    MEM_NOP, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
  } mem_op_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        mem_read;
    logic        branch;
    logic        jump;
    comp_op_t    comp;
    reg_wr_src_t wr_src;
    alu_src1_t   src1;
    alu_src2_t   src2;
    alu_op_t     alu;
    mem_op_t     mem;
  } ctrl_t;

  // Control word of a bubble: nothing written, nothing accessed, no redirect.
  localparam ctrl_t CTRL_DEFAULT = '{
    reg_write: 1'b0,
    mem_write: 1'b0,
    mem_read:  1'b0,
    branch:    1'b0,
    jump:      1'b0,
    comp:      BR_NOP,
    wr_src:    WRSRC_ALURES,
    src1:      SRC1_REG1,
    src2:      SRC2_REG2,
    alu:       ALU_NOP,
    mem:       MEM_NOP
  };

  // Register-register and register-immediate arithmetic; also LUI/AUIPC base.
  function automatic ctrl_t ctrl_alu(alu_op_t op, alu_src2_t src2);
    ctrl_t c;
    c           = CTRL_DEFAULT;
    c.reg_write = 1'b1;
    c.src2      = src2;
    c.alu       = op;
    return c;
  endfunction

  // Loads: address = rs1 + imm, result comes back from memory.
  function automatic ctrl_t ctrl_load(mem_op_t m);
    ctrl_t c;
    c           = CTRL_DEFAULT;
    c.reg_write = 1'b1;
    c.mem_read  = 1'b1;
    c.wr_src    = WRSRC_MEMREAD;
    c.src2      = SRC2_IMM;
    c.alu       = ALU_ADD;
    c.mem       = m;
    return c;
  endfunction

  // Stores: address = rs1 + imm, no register write-back.
  function automatic ctrl_t ctrl_store(mem_op_t m);
    ctrl_t c;
    c           = CTRL_DEFAULT;
    c.mem_write = 1'b1;
    c.src2      = SRC2_IMM;
    c.alu       = ALU_ADD;
    c.mem       = m;
    return c;
  endfunction

  // Branches: the ALU forms the target PC + imm while the comparator
  // evaluates rs1 against rs2.
  function automatic ctrl_t ctrl_branch(comp_op_t cmp);
    ctrl_t c;
    c        = CTRL_DEFAULT;
    c.branch = 1'b1;
    c.comp   = cmp;
    c.src1   = SRC1_PC;
    c.src2   = SRC2_IMM;
    c.alu    = ALU_ADD;
    return c;
  endfunction

  // JAL (base = PC) and JALR (base = rs1): link register receives PC+4.
  function automatic ctrl_t ctrl_jump(alu_src1_t base);
    ctrl_t c;
    c           = CTRL_DEFAULT;
    c.reg_write = 1'b1;
    c.jump      = 1'b1;
    c.wr_src    = WRSRC_PC4;
    c.src1      = base;
    c.src2      = SRC2_IMM;
    c.alu       = ALU_ADD;
    return c;
  endfunction

endpackage

// File: rtl/control_if.sv
// -----------------------------------------------------------------------------
// control_if
//   Decoder-facing bundle of the ID stage.
//     opcode_in          pre-decoded instruction (driven by the ID stage)
//     reg_do_write_ctrl  register-file write enable for rd
//     mem_do_write_ctrl  data-memory store enable
//     mem_do_read_ctrl   data-memory load enable
//     do_branch          conditional branch, taken when comp_ctrl holds
//     do_jump            unconditional jump (JAL/JALR)
//     comp_ctrl          branch comparator op
//     reg_wr_src_ctrl    rd write-back source
//     alu_src1_ctrl      ALU operand A select
//     alu_src2_ctrl      ALU operand B select
//     alu_ctrl           ALU operation
//     mem_ctrl           memory access width/sign
//   Modports:
//     master - the ID stage: drives opcode_in, consumes the control signals
//     slave  - the decoder: consumes opcode_in, drives the control signals
// -----------------------------------------------------------------------------
interface control_if;
  import control_pkg::*;

  opcode_out_t opcode_in;
  logic        reg_do_write_ctrl;
  logic        mem_do_write_ctrl;
  logic        mem_do_read_ctrl;
  logic        do_branch;
  logic        do_jump;
  comp_op_t    comp_ctrl;
  reg_wr_src_t reg_wr_src_ctrl;
  alu_src1_t   alu_src1_ctrl;
  alu_src2_t   alu_src2_ctrl;
  alu_op_t     alu_ctrl;
  mem_op_t     mem_ctrl;

  modport master (
    output opcode_in,
    input  reg_do_write_ctrl, mem_do_write_ctrl, mem_do_read_ctrl,
    input  do_branch, do_jump, comp_ctrl, reg_wr_src_ctrl,
    input  alu_src1_ctrl, alu_src2_ctrl, alu_ctrl, mem_ctrl
  );

  modport slave (
    input  opcode_in,
    output reg_do_write_ctrl, mem_do_write_ctrl, mem_do_read_ctrl,
    output do_branch, do_jump, comp_ctrl, reg_wr_src_ctrl,
    output alu_src1_ctrl, alu_src2_ctrl, alu_ctrl, mem_ctrl
  );

endinterface

// File: rtl/control.sv
// -----------------------------------------------------------------------------
// control
//   ID-stage main decoder of the 5-stage RV32I pipeline. Maps the pre-decoded
//   opcode to every datapath control signal. Purely combinational: outputs
//   follow opcode_in in the same cycle, regardless of rst_n. The ID/EX
//   pipeline register downstream captures them.
//   Ports:
//     clk    clock (present for interface uniformity, no state here)
//     rst_n  synchronous active-low reset (likewise unused: outputs are never
//            reset, a bubble is expressed by driving OP_NOP)
//     ctl    control_if.slave - opcode in, control signals out
// -----------------------------------------------------------------------------
module control
  import control_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  control_if.slave  ctl
);

  ctrl_t c;

  // clk/rst_n are intentionally not consumed by any logic.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  always_comb begin
    // NOTE: every field gets its default before the case, so any path that
    // does not override a field still assigns it and no latch is inferred.
    c = CTRL_DEFAULT;
    case (ctl.opcode_in)
      OP_LUI:   c = ctrl_alu(ALU_LUI, SRC2_IMM);
      OP_AUIPC: begin
        c      = ctrl_alu(ALU_ADD, SRC2_IMM);
        c.src1 = SRC1_PC;
      end
      OP_JAL:   c = ctrl_jump(SRC1_PC);
      OP_JALR:  c = ctrl_jump(SRC1_REG1);

      OP_BEQ:   c = ctrl_branch(BR_EQ);
      OP_BNE:   c = ctrl_branch(BR_NE);
      OP_BLT:   c = ctrl_branch(BR_LT);
      OP_BGE:   c = ctrl_branch(BR_GE);
      OP_BLTU:  c = ctrl_branch(BR_LTU);
      OP_BGEU:  c = ctrl_branch(BR_GEU);

      OP_LB:    c = ctrl_load(MEM_LB);
      OP_LH:    c = ctrl_load(MEM_LH);
      OP_LW:    c = ctrl_load(MEM_LW);
      OP_LBU:   c = ctrl_load(MEM_LBU);
      OP_LHU:   c = ctrl_load(MEM_LHU);

      OP_SB:    c = ctrl_store(MEM_SB);
      OP_SH:    c = ctrl_store(MEM_SH);
      OP_SW:    c = ctrl_store(MEM_SW);

      OP_ADDI:  c = ctrl_alu(ALU_ADD,  SRC2_IMM);
      OP_SLTI:  c = ctrl_alu(ALU_SLT,  SRC2_IMM);
      OP_SLTIU: c = ctrl_alu(ALU_SLTU, SRC2_IMM);
      OP_XORI:  c = ctrl_alu(ALU_XOR,  SRC2_IMM);
      OP_ORI:   c = ctrl_alu(ALU_OR,   SRC2_IMM);
      OP_ANDI:  c = ctrl_alu(ALU_AND,  SRC2_IMM);
      OP_SLLI:  c = ctrl_alu(ALU_SLL,  SRC2_IMM);
      OP_SRLI:  c = ctrl_alu(ALU_SRL,  SRC2_IMM);
      OP_SRAI:  c = ctrl_alu(ALU_SRA,  SRC2_IMM);

      OP_ADD:   c = ctrl_alu(ALU_ADD,  SRC2_REG2);
      OP_SUB:   c = ctrl_alu(ALU_SUB,  SRC2_REG2);
      OP_SLL:   c = ctrl_alu(ALU_SLL,  SRC2_REG2);
      OP_SLT:   c = ctrl_alu(ALU_SLT,  SRC2_REG2);
      OP_SLTU:  c = ctrl_alu(ALU_SLTU, SRC2_REG2);
      OP_XOR:   c = ctrl_alu(ALU_XOR,  SRC2_REG2);
      OP_SRL:   c = ctrl_alu(ALU_SRL,  SRC2_REG2);
      OP_SRA:   c = ctrl_alu(ALU_SRA,  SRC2_REG2);
      OP_OR:    c = ctrl_alu(ALU_OR,   SRC2_REG2);
      OP_AND:   c = ctrl_alu(ALU_AND,  SRC2_REG2);

      // OP_NOP and encodings beyond the enum keep the bubble word.
      default:  c = CTRL_DEFAULT;
    endcase
  end

  assign ctl.reg_do_write_ctrl = c.reg_write;
  assign ctl.mem_do_write_ctrl = c.mem_write;
  assign ctl.mem_do_read_ctrl  = c.mem_read;
  assign ctl.do_branch         = c.branch;
  assign ctl.do_jump           = c.jump;
  assign ctl.comp_ctrl         = c.comp;
  assign ctl.reg_wr_src_ctrl   = c.wr_src;
  assign ctl.alu_src1_ctrl     = c.src1;
  assign ctl.alu_src2_ctrl     = c.src2;
  assign ctl.alu_ctrl          = c.alu;
  assign ctl.mem_ctrl          = c.mem;

endmodule

// File: tb/tb_control.sv
// -----------------------------------------------------------------------------
// tb_control
//   Directed bench for the ID-stage main decoder. Each step drives an opcode
//   (and rst_n) on the falling clock edge, waits 1 ns and compares all eleven
//   control outputs against a hand-written expected row, then checks the
//   decoder invariants and the absence of X.
// -----------------------------------------------------------------------------
module tb_control;
  import control_pkg::*;

  typedef struct {
    logic        rw;
    logic        mw;
    logic        mr;
    logic        br;
    logic        jp;
    comp_op_t    comp;
    reg_wr_src_t src;
    alu_src1_t   s1;
    alu_src2_t   s2;
    alu_op_t     alu;
    mem_op_t     mem;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  control_if ctl ();

  control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (ctl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(logic rw, logic mw, logic mr, logic br, logic jp,
                              comp_op_t comp, reg_wr_src_t src, alu_src1_t s1,
                              alu_src2_t s2, alu_op_t alu, mem_op_t mem);
    exp_t e;
    e.rw = rw; e.mw = mw; e.mr = mr; e.br = br; e.jp = jp;
    e.comp = comp; e.src = src; e.s1 = s1; e.s2 = s2; e.alu = alu; e.mem = mem;
    return e;
  endfunction

  // Hand-written expected control word for every opcode.
  function automatic exp_t expect_for(opcode_out_t op);
    case (op)
      OP_LUI:   return mk(1,0,0,0,0, BR_NOP, WRSRC_ALURES,  SRC1_REG1, SRC2_IMM,  ALU_LUI,  MEM_NOP);
      OP_AUIPC: return mk(1,0,0,0,0, BR_NOP, WRSRC_ALURES,  SRC1_PC,   SRC2_IMM,  ALU_ADD,  MEM_NOP);
      OP_JAL:   return mk(1,0,0,0,1, BR_NOP, WRSRC_PC4,     SRC1_PC,   SRC2_IMM,  ALU_ADD,  MEM_NOP);
      OP_JALR:  return mk(1,0,0,0,1, BR_NOP, WRSRC_PC4,     SRC1_REG1, SRC2_IMM,  ALU_ADD,  MEM_NOP);
      OP_BEQ:   return mk(0,0,0,1,0, BR_EQ,  WRSRC_ALURES,  SRC1_PC,   SRC2_IMM,  ALU_ADD,  MEM_NOP);
      OP_BNE:   return mk(0,0,0,1,0, BR_NE,  WRSRC_ALURES,  SRC1_PC,   SRC2_IMM,  ALU_ADD,  MEM_NOP);
      OP_BLT:   return mk(0,0,0,1,0, BR_LT,  WRSRC_ALURES,  SRC1_PC,   SRC2_IMM,  ALU_ADD,  MEM_NOP);
      OP_BGE:   return mk(0,0,0,1,0, BR_GE,  WRSRC_ALURES,  SRC1_PC,   SRC2_IMM,  ALU_ADD,  MEM_NOP);
      OP_BLTU:  return mk(0,0,0,1,0, BR_LTU, WRSRC_ALURES,  SRC1_PC,   SRC2_IMM,  ALU_ADD,  MEM_NOP);
      OP_BGEU:  return mk(0,0,0,1,0, BR_GEU, WRSRC_ALURES,  SRC1_PC,   SRC2_IMM,  ALU_ADD,  MEM_NOP);
      OP_LB:    return mk(1,0,1,0,0, BR_NOP, WRSRC_MEMREAD, SRC1_REG1, SRC2_IMM,  ALU_ADD,  MEM_LB);
      OP_LH:    return mk(1,0,1,0,0, BR_NOP, WRSRC_MEMREAD, SRC1_REG1, SRC2_IMM,  ALU_ADD,  MEM_LH);
      OP_LW:    return mk(1,0,1,0,0, BR_NOP, WRSRC_MEMREAD, SRC1_REG1, SRC2_IMM,  ALU_ADD,  MEM_LW);
      OP_LBU:   return mk(1,0,1,0,0, BR_NOP, WRSRC_MEMREAD, SRC1_REG1, SRC2_IMM,  ALU_ADD,  MEM_LBU);
      OP_LHU:   return mk(1,0,1,0,0, BR_NOP, WRSRC_MEMREAD, SRC1_REG1, SRC2_IMM,  ALU_ADD,  MEM_LHU);
      OP_SB:    return mk(0,1,0,0,0, BR_NOP, WRSRC_ALURES,  SRC1_REG1, SRC2_IMM,  ALU_ADD,  MEM_SB);
      OP_SH:    return mk(0,1,0,0,0, BR_NOP, WRSRC_ALURES,  SRC1_REG1, SRC2_IMM,  ALU_ADD,  MEM_SH);
      OP_SW:    return mk(0,1,0,0,0, BR_NOP, WRSRC_ALURES,  SRC1_REG1, SRC2_IMM,  ALU_ADD,  MEM_SW);
      OP_ADDI:  return mk(1,0,0,0,0, BR_NOP, WRSRC_ALURES,  SRC1_REG1, SRC2_IMM,  ALU_ADD,  MEM_NOP);
      OP_SLTI:  return mk(1,0,0,0,0, BR_NOP, WRSRC_ALURES,  SRC1_REG1, SRC2_IMM,  ALU_SLT,  MEM_NOP);
      OP_SLTIU: return mk(1,0,0,0,0, BR_NOP, WRSRC_ALURES,  SRC1_REG1, SRC2_IMM,  ALU_SLTU, MEM_NOP);
      OP_XORI:  return mk(1,0,0,0,0, BR_NOP, WRSRC_ALURES,  SRC1_REG1, SRC2_IMM,  ALU_XOR,  MEM_NOP);
      OP_ORI:   return mk(1,0,0,0,0, BR_NOP, WRSRC_ALURES,  SRC1_REG1, SRC2_IMM,  ALU_OR,   MEM_NOP);
      OP_ANDI:  return mk(1,0,0,0,0, BR_NOP, WRSRC_ALURES,  SRC1_REG1, SRC2_IMM,  ALU_AND,  MEM_NOP);
      OP_SLLI:  return mk(1,0,0,0,0, BR_NOP, WRSRC_ALURES,  SRC1_REG1, SRC2_IMM,  ALU_SLL,  MEM_NOP);
      OP_SRLI:  return mk(1,0,0,0,0, BR_NOP, WRSRC_ALURES,  SRC1_REG1, SRC2_IMM,  ALU_SRL,  MEM_NOP);
      OP_SRAI:  return mk(1,0,0,0,0, BR_NOP, WRSRC_ALURES,  SRC1_REG1, SRC2_IMM,  ALU_SRA,  MEM_NOP);
      OP_ADD:   return mk(1,0,0,0,0, BR_NOP, WRSRC_ALURES,  SRC1_REG1, SRC2_REG2, ALU_ADD,  MEM_NOP);
      OP_SUB:   return mk(1,0,0,0,0, BR_NOP, WRSRC_ALURES,  SRC1_REG1, SRC2_REG2, ALU_SUB,  MEM_NOP);
      OP_SLL:   return mk(1,0,0,0,0, BR_NOP, WRSRC_ALURES,  SRC1_REG1, SRC2_REG2, ALU_SLL,  MEM_NOP);
      OP_SLT:   return mk(1,0,0,0,0, BR_NOP, WRSRC_ALURES,  SRC1_REG1, SRC2_REG2, ALU_SLT,  MEM_NOP);
      OP_SLTU:  return mk(1,0,0,0,0, BR_NOP, WRSRC_ALURES,  SRC1_REG1, SRC2_REG2, ALU_SLTU, MEM_NOP);
      OP_XOR:   return mk(1,0,0,0,0, BR_NOP, WRSRC_ALURES,  SRC1_REG1, SRC2_REG2, ALU_XOR,  MEM_NOP);
      OP_SRL:   return mk(1,0,0,0,0, BR_NOP, WRSRC_ALURES,  SRC1_REG1, SRC2_REG2, ALU_SRL,  MEM_NOP);
      OP_SRA:   return mk(1,0,0,0,0, BR_NOP, WRSRC_ALURES,  SRC1_REG1, SRC2_REG2, ALU_SRA,  MEM_NOP);
      OP_OR:    return mk(1,0,0,0,0, BR_NOP, WRSRC_ALURES,  SRC1_REG1, SRC2_REG2, ALU_OR,   MEM_NOP);
      OP_AND:   return mk(1,0,0,0,0, BR_NOP, WRSRC_ALURES,  SRC1_REG1, SRC2_REG2, ALU_AND,  MEM_NOP);
      default:  return mk(0,0,0,0,0, BR_NOP, WRSRC_ALURES,  SRC1_REG1, SRC2_REG2, ALU_NOP,  MEM_NOP);
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic apply(input logic [5:0] raw, input logic rst);
    @(negedge clk);
    ctl.opcode_in = opcode_out_t'(raw);
    rst_n         = rst;
    #1;
  endtask

  task automatic check_vec(input string tag, input exp_t e);
    check({tag, ".reg_write"},  8'(ctl.reg_do_write_ctrl), 8'(e.rw));
    check({tag, ".mem_write"},  8'(ctl.mem_do_write_ctrl), 8'(e.mw));
    check({tag, ".mem_read"},   8'(ctl.mem_do_read_ctrl),  8'(e.mr));
    check({tag, ".do_branch"},  8'(ctl.do_branch),         8'(e.br));
    check({tag, ".do_jump"},    8'(ctl.do_jump),           8'(e.jp));
    check({tag, ".comp"},       8'(ctl.comp_ctrl),         8'(e.comp));
    check({tag, ".wr_src"},     8'(ctl.reg_wr_src_ctrl),   8'(e.src));
    check({tag, ".src1"},       8'(ctl.alu_src1_ctrl),     8'(e.s1));
    check({tag, ".src2"},       8'(ctl.alu_src2_ctrl),     8'(e.s2));
    check({tag, ".alu"},        8'(ctl.alu_ctrl),          8'(e.alu));
    check({tag, ".mem"},        8'(ctl.mem_ctrl),          8'(e.mem));
  endtask

  task automatic check_invariants(input string tag);
    check({tag, ".no_x"}, 8'($isunknown({ctl.reg_do_write_ctrl, ctl.mem_do_write_ctrl,
                                          ctl.mem_do_read_ctrl, ctl.do_branch, ctl.do_jump,
                                          ctl.comp_ctrl, ctl.reg_wr_src_ctrl, ctl.alu_src1_ctrl,
                                          ctl.alu_src2_ctrl, ctl.alu_ctrl, ctl.mem_ctrl})), 8'd0);
    check({tag, ".rd_and_wr"}, 8'(ctl.mem_do_read_ctrl & ctl.mem_do_write_ctrl), 8'd0);
    check({tag, ".br_and_jmp"}, 8'(ctl.do_branch & ctl.do_jump), 8'd0);
    check({tag, ".comp_wo_br"}, 8'((ctl.comp_ctrl != BR_NOP) && !ctl.do_branch), 8'd0);
  endtask

  task automatic step(input string tag, input opcode_out_t op, input logic rst);
    apply(op, rst);
    check_vec(tag, expect_for(op));
  endtask

  initial begin
    n_total       = 0;
    n_pass        = 0;
    rst_n         = 1'b0;
    ctl.opcode_in = OP_NOP;

    // Outputs are live during reset: NOP gives the bubble word, ADD decodes fully.
    step("nop_rst",  OP_NOP,  1'b0);
    step("add_rst",  OP_ADD,  1'b0);

    step("add",   OP_ADD,   1'b1);
    step("addi",  OP_ADDI,  1'b1);
    step("lw",    OP_LW,    1'b1);
    step("sw",    OP_SW,    1'b1);
    step("beq",   OP_BEQ,   1'b1);
    step("bne",   OP_BNE,   1'b1);
    step("blt",   OP_BLT,   1'b1);
    step("bge",   OP_BGE,   1'b1);
    step("bltu",  OP_BLTU,  1'b1);
    step("bgeu",  OP_BGEU,  1'b1);
    step("jal",   OP_JAL,   1'b1);
    step("jalr",  OP_JALR,  1'b1);
    step("lui",   OP_LUI,   1'b1);
    step("auipc", OP_AUIPC, 1'b1);
    step("nop",   OP_NOP,   1'b1);

    // Every 6-bit encoding (listed and unlisted) under both reset levels.
    for (int i = 0; i < 64; i++) begin
      logic [5:0] raw;
      raw = i[5:0];
      for (int r = 0; r < 2; r++) begin
        apply(raw, r[0]);
        check_vec($sformatf("sweep%0d_rst%0d", i, r), expect_for(opcode_out_t'(raw)));
        check_invariants($sformatf("sweep%0d_rst%0d", i, r));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
